// File: rtl/pipe_latch_skid.sv
// Two-entry pipeline latch (OUT + SKID) between pipe stages: 1-cycle latency, full throughput.
// Back-pressure: i_ready low holds OUT, one extra entry parks in SKID, o_ready drops only when both are full.
module pipe_latch_skid #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OUT_HOLD      = 2'd0,
    OUT_LOAD_IN   = 2'd1,
    OUT_LOAD_SKID = 2'd2,
    OUT_CLEAR     = 2'd3
  } out_sel_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  out_sel_t         out_sel;
  entry_t           out_q, skid_q, in_ent;
  logic             skid_load, skid_clear;
  logic             accept, emit, stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  // Handshake outputs come straight from the state register, no input paths.
  assign o_valid     = (state != EMPTY);
  assign o_ready     = (state != TWO);
  assign o_data      = out_q.data;
  assign o_ctrl      = o_valid ? out_q.ctrl : '0;
  assign o_stall_cnt = stall_q;
  assign o_flush_cnt = flush_q;

  assign accept    = i_step && i_valid && o_ready && !i_flush;
  assign emit      = i_step && o_valid && i_ready && !i_flush;
  assign stall_inc = i_step && o_valid && !i_ready && !i_flush;
  assign flush_inc = i_flush && o_valid;

  always_comb begin
    in_ent      = '0;
    in_ent.ctrl = i_ctrl;
    in_ent.data = i_data;
  end

  always_comb begin
    state_nxt  = state;
    out_sel    = OUT_HOLD;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (i_flush) begin
      // Flush wins over step: drop everything including the incoming entry.
      state_nxt  = EMPTY;
      out_sel    = OUT_CLEAR;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt = ONE;
            out_sel   = OUT_LOAD_IN;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_sel = OUT_LOAD_IN;
          end else if (accept) begin
            state_nxt = TWO;
            skid_load = 1'b1;
          end else if (emit) begin
            state_nxt = EMPTY;
            out_sel   = OUT_CLEAR;
          end
        end
        TWO: begin
          if (emit) begin
            state_nxt  = ONE;
            out_sel    = OUT_LOAD_SKID;
            skid_clear = 1'b1;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          out_sel    = OUT_CLEAR;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      unique case (out_sel)
        OUT_LOAD_IN:   out_q <= in_ent;
        OUT_LOAD_SKID: out_q <= skid_q;
        OUT_CLEAR:     out_q <= '0;
        default:       out_q <= out_q;
      endcase
      if (skid_clear) begin
        skid_q <= '0;
      end else if (skid_load) begin
        skid_q <= in_ent;
      end
    end
  end

  // Saturating statistics; they never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (flush_inc && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_latch_skid.sv
module tb_pipe_latch_skid;

  localparam int DW   = 32;
  localparam int CW   = 12;
  localparam int NW   = 4;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst, step, flush, vin, rdy;
  logic [DW-1:0] din;
  logic [CW-1:0] cin;
  logic          o_ready, o_valid;
  logic [DW-1:0] o_data;
  logic [CW-1:0] o_ctrl;
  logic [NW-1:0] o_stall_cnt, o_flush_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t mq[$];
  int   m_stall, m_flush;

  always #5 clk = ~clk;

  pipe_latch_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_step      (step),
    .i_flush     (flush),
    .i_valid     (vin),
    .o_ready     (o_ready),
    .i_data      (din),
    .i_ctrl      (cin),
    .o_valid     (o_valid),
    .i_ready     (rdy),
    .o_data      (o_data),
    .o_ctrl      (o_ctrl),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic compare(input string ph);
    logic [CW-1:0] ec;
    ec = '0;
    chk({ph, ":o_valid"}, 64'(o_valid), 64'(mq.size() != 0));
    chk({ph, ":o_ready"}, 64'(o_ready), 64'(mq.size() < 2));
    if (mq.size() != 0) begin
      chk({ph, ":o_data"}, 64'(o_data), 64'(mq[0].d));
      ec = mq[0].c;
    end
    chk({ph, ":o_ctrl"}, 64'(o_ctrl), 64'(ec));
    chk({ph, ":stall_cnt"}, 64'(o_stall_cnt), 64'(m_stall));
    chk({ph, ":flush_cnt"}, 64'(o_flush_cnt), 64'(m_flush));
  endtask

  // One clock: the reference is a plain FIFO of at most two entries.
  task automatic cyc(input string ph);
    bit   acc, emi;
    ent_t e;
    acc = step && vin && (mq.size() < 2) && !flush;
    emi = step && (mq.size() > 0) && rdy && !flush;
    @(posedge clk);
    #1;
    if (flush) begin
      if (mq.size() > 0 && m_flush < CMAX) m_flush++;
      mq.delete();
    end else begin
      if (step && mq.size() > 0 && !rdy && m_stall < CMAX) m_stall++;
      if (emi) void'(mq.pop_front());
      if (acc) begin
        e.d = din;
        e.c = cin;
        mq.push_back(e);
      end
    end
    compare(ph);
  endtask

  // Assert reset between edges and check outputs before the next edge.
  task automatic async_reset(input string ph);
    #2 rst = 1'b1;
    #1;
    mreset();
    compare(ph);
    chk({ph, ":o_data_zero"}, 64'(o_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; step = 1'b1; flush = 1'b0; vin = 1'b0; rdy = 1'b0;
    din = '0; cin = '0;
    mreset();
    #12;
    compare("reset");
    chk("reset:o_data_zero", 64'(o_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming at full rate
    rdy = 1'b1; vin = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din = DW'(k);
      cin = CW'(12'h100 + k);
      cyc("stream");
      chk("stream:data", 64'(o_data), 64'(k));
    end
    vin = 1'b0;
    cyc("drain");

    // Back-pressure fills the skid slot
    rdy = 1'b0; vin = 1'b1;
    din = 32'hA; cin = 12'h0A1; cyc("bp_a");
    din = 32'hB; cin = 12'h0B2; cyc("bp_b");
    chk("bp:o_ready_low", 64'(o_ready), 64'd0);
    chk("bp:o_data_a", 64'(o_data), 64'hA);
    vin = 1'b0;
    cyc("bp_hold");
    cyc("bp_hold");
    chk("bp:stall_cnt", 64'(o_stall_cnt), 64'd3);
    rdy = 1'b1;
    cyc("bp_emit_a");
    chk("bp:o_data_b", 64'(o_data), 64'hB);
    cyc("bp_emit_b");

    // Flush from TWO drops the incoming entry too
    rdy = 1'b0; vin = 1'b1;
    din = 32'h1; cin = 12'hFFF; cyc("fl_fill");
    din = 32'h2; cyc("fl_fill");
    flush = 1'b1; din = 32'hC; cin = 12'h0C3;
    cyc("flush_two");
    chk("flush:o_data_zero", 64'(o_data), 64'd0);
    chk("flush:cnt_one", 64'(o_flush_cnt), 64'd1);
    vin = 1'b0;
    cyc("flush_empty");
    chk("flush:cnt_stays", 64'(o_flush_cnt), 64'd1);
    flush = 1'b0; rdy = 1'b1;
    cyc("flush_after");

    // Step freeze in ONE
    rdy = 1'b0; vin = 1'b1; din = 32'h55; cin = 12'h3C5;
    cyc("fz_load");
    step = 1'b0; rdy = 1'b1; din = 32'h66;
    repeat (5) cyc("freeze");
    chk("freeze:o_data", 64'(o_data), 64'h55);
    flush = 1'b1;
    cyc("freeze_flush");
    flush = 1'b0; step = 1'b1; vin = 1'b0;

    // Stall counter saturation
    async_reset("rst_sat");
    vin = 1'b1; rdy = 1'b0; din = 32'h77; cin = 12'h011;
    cyc("sat_load");
    vin = 1'b0;
    repeat (20) cyc("sat");
    chk("sat:stall_15", 64'(o_stall_cnt), 64'd15);

    // Async reset while in TWO, then restart clean
    vin = 1'b1; din = 32'h88; cyc("ar_fill");
    chk("ar:in_two", 64'(o_ready), 64'd0);
    async_reset("rst_two");
    vin = 1'b0; rdy = 1'b1;
    cyc("ar_release");

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      step  = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 24) == 0);
      vin   = 1'($urandom_range(0, 1));
      rdy   = ($urandom_range(0, 2) != 0);
      din   = $urandom();
      cin   = CW'($urandom());
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 Parameter DATA_W, default 128, SHALL set the width of the datapath payload (jump address, PC-to-reg, ALU result, rt value).
REQ-002 Parameter CTRL_W, default 12, SHALL set the width of the control payload (write-PC, taken, RegWrite, MemtoReg, MemWrite, MemRead, stop-pipe, load/store type, destination register).
REQ-003 Parameter CNT_W, default 16, SHALL set the width of the statistics counters.
REQ-004 clk  in  1  SHALL be the only clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 i_step  in  1  SHALL be the debug step enable; when low, handshake state, payload and counters hold.
REQ-007 i_flush  in  1  SHALL discard all held entries (taken jump).
REQ-008 i_valid  in  1  SHALL mark upstream payload valid.
REQ-009 o_ready  out  1  SHALL indicate the block can accept an entry this cycle.
REQ-010 i_data  in  DATA_W  SHALL be the upstream datapath payload.
REQ-011 i_ctrl  in  CTRL_W  SHALL be the upstream control payload.
REQ-012 o_valid  out  1  SHALL mark the downstream payload valid.
REQ-013 i_ready  in  1  SHALL indicate downstream acceptance.
REQ-014 o_data  out  DATA_W  SHALL be the downstream datapath payload.
REQ-015 o_ctrl  out  CTRL_W  SHALL be the downstream control payload.
REQ-016 o_stall_cnt  out  CNT_W  SHALL count output back-pressure cycles.
REQ-017 o_flush_cnt  out  CNT_W  SHALL count flushes that discarded a valid entry.

Function
REQ-018 Storage SHALL be two entries: OUT register (drives o_data/o_ctrl) and SKID register; order strictly FIFO.
REQ-019 State SHALL be EMPTY (no entries), ONE (OUT full, SKID empty) or TWO (both full); o_valid = (state != EMPTY); o_ready = (state != TWO), driven from registered state only.
REQ-020 Accept SHALL occur when i_step && i_valid && o_ready && !i_flush; emit SHALL occur when i_step && o_valid && i_ready && !i_flush.
REQ-021 EMPTY + accept SHALL load OUT, go to ONE; latency input-to-o_valid exactly 1 cycle.
REQ-022 ONE + accept + emit SHALL load OUT with new entry, stay ONE (throughput 1 entry/cycle).
REQ-023 ONE + accept without emit SHALL load SKID, go to TWO; ONE + emit without accept SHALL go to EMPTY.
REQ-024 TWO + emit SHALL move SKID into OUT, go to ONE; TWO never accepts.
REQ-025 o_ctrl SHALL read all zeros whenever o_valid is low, so bubbles carry no write/memory enables.
REQ-026 i_flush SHALL act regardless of i_step: next state EMPTY, OUT and SKID payloads cleared to zero, incoming entry dropped, no emit counted.
REQ-027 i_step low without i_flush SHALL freeze state, payloads and counters; o_valid/o_ready keep their values.
REQ-028 o_stall_cnt SHALL increment on each cycle with i_step && o_valid && !i_ready && !i_flush, saturating at all-ones.
REQ-029 o_flush_cnt SHALL increment on each cycle with i_flush && o_valid, saturating at all-ones; flush while EMPTY does not count.
REQ-030 No payload bits SHALL change in a cycle without accept, emit, flush or reset.

Reset
REQ-031 rst high SHALL immediately force state EMPTY, OUT, SKID, o_stall_cnt, o_flush_cnt to zero; o_valid=0, o_ready=1, o_data=0, o_ctrl=0.
REQ-032 rst SHALL override i_flush and i_step; release mid-transfer SHALL restart from EMPTY with no stale entry emitted.

Verification
REQ-033 Streaming: i_step=1, i_ready=1, i_valid=1, data 1,2,3,4 on successive cycles -> o_data 1,2,3,4 one cycle later, o_ready stays 1, o_stall_cnt=0.
REQ-034 Back-pressure: load 0xA, 0xB with i_ready=0 -> state TWO, o_ready=0, o_data=0xA; raise i_ready -> 0xA then 0xB emitted, o_stall_cnt equals stalled cycles.
REQ-035 Flush: state TWO, i_flush=1 with i_valid=1 data 0xC -> next cycle o_valid=0, o_ctrl=0, o_data=0, 0xC never emitted, o_flush_cnt=1; flush again while EMPTY -> o_flush_cnt stays 1.
REQ-036 Step freeze: state ONE, i_step=0, i_valid=1, i_ready=1 for 5 cycles -> o_data unchanged, no accept/emit, counters unchanged; i_flush during i_step=0 still empties.
REQ-037 Saturation: CNT_W=4, hold i_ready=0 with o_valid=1 for 20 stepped cycles -> o_stall_cnt=15.
REQ-038 Async reset: assert rst between clock edges in state TWO -> o_valid=0, o_ready=1, counters 0 before next edge.
